// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw board pins in, conditioned
// control levels and event pulses out.
interface input_conditioner_if #(
  parameter int SW_WIDTH = 10
);
  logic [SW_WIDTH-1:0] sw_raw;
  logic                key_raw;
  logic [SW_WIDTH-1:0] sw_clean;
  logic                sw_change;
  logic                key_pressed;
  logic                key_press_pulse;
  logic                key_release_pulse;
  logic                key_hold_pulse;

  modport master (
    output sw_raw,
    output key_raw,
    input  sw_clean,
    input  sw_change,
    input  key_pressed,
    input  key_press_pulse,
    input  key_release_pulse,
    input  key_hold_pulse
  );

  modport slave (
    input  sw_raw,
    input  key_raw,
    output sw_clean,
    output sw_change,
    output key_pressed,
    output key_press_pulse,
    output key_release_pulse,
    output key_hold_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronize and debounce switches and
// KEY[1], then derive press/hold/release event pulses.
module input_conditioner #(
  parameter int SW_WIDTH    = 10,
  parameter int DB_CYCLES   = 100000,
  parameter int HOLD_CYCLES = 10000000
) (
  input logic ADC_CLK_10,
  input logic reset_n,
  input_conditioner_if.slave bus
);

  // switch bits occupy [SW_WIDTH-1:0], the key sits on top
  localparam int N  = SW_WIDTH + 1;
  localparam int KB = SW_WIDTH;
  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [N-1:0] RST_LVL =
    {1'b1, {SW_WIDTH{1'b0}}};
  localparam logic [CW-1:0] DB_LAST =
    CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic [N-1:0]  raw;
  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  clean;
  logic [N-1:0]  differ;
  logic [N-1:0]  load;
  logic [CW-1:0] cnt [N];

  logic          sw_change_q;
  logic          press_ev;
  logic          rel_ev;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          press_q;
  logic          rel_q;
  logic          hold_q;

  assign raw = {bus.key_raw, bus.sw_raw};

  // per-bit disagreement and terminal-count update strobes
  always_comb begin
    differ = '0;
    load   = '0;
    for (int i = 0; i < N; i++) begin
      differ[i] = sync2[i] != clean[i];
      load[i]   = differ[i] && (cnt[i] == DB_LAST);
    end
  end

  // debounced key moving to pressed (low) or released (high)
  assign press_ev = load[KB] && !sync2[KB];
  assign rel_ev   = load[KB] &&  sync2[KB];

  // two-flop synchronizer, per-bit debounce counters
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= RST_LVL;
      sync2       <= RST_LVL;
      clean       <= RST_LVL;
      sw_change_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      sw_change_q <= |load[SW_WIDTH-1:0];
      for (int i = 0; i < N; i++) begin
        if (!differ[i]) begin
          cnt[i] <= '0;
        end else if (load[i]) begin
          clean[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // press/hold/release tracker; release wins over hold
  always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hold_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press_ev) begin
            press_q  <= 1'b1;
            hold_cnt <= '0;
            state    <= PRESSED;
          end
        end
        PRESSED: begin
          if (rel_ev) begin
            rel_q <= 1'b1;
            state <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_q <= 1'b1;
            state  <= HELD;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        HELD: begin
          if (rel_ev) begin
            rel_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sw_clean          = clean[SW_WIDTH-1:0];
  assign bus.sw_change         = sw_change_q;
  assign bus.key_pressed       = ~clean[KB];
  assign bus.key_press_pulse   = press_q;
  assign bus.key_release_pulse = rel_q;
  assign bus.key_hold_pulse    = hold_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios, a behavioural
// model checked every cycle, and hand-computed pins.
module tb_input_conditioner;

  localparam int SW   = 10;
  localparam int N    = SW + 1;
  localparam int DB   = 4;
  localparam int HOLD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  input_conditioner_if #(.SW_WIDTH(SW)) bus ();

  input_conditioner #(
    .SW_WIDTH   (SW),
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .ADC_CLK_10(clk),
    .reset_n   (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_hold = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h",
               name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // raw pins reach the debouncer two edges late; a level
  // is accepted after DB consecutive disagreeing samples.
  logic [N-1:0] rst_lvl = {1'b1, {SW{1'b0}}};
  logic [N-1:0] hist [$];
  logic [N-1:0] dly;
  logic [N-1:0] upd;
  logic [N-1:0] m_clean = {1'b1, {SW{1'b0}}};
  int           run [N];
  int           cyc       = 0;
  int           press_at  = 0;
  bit           holding   = 0;
  bit           hold_done = 0;
  logic m_change = 0;
  logic m_press  = 0;
  logic m_rel    = 0;
  logic m_hold   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      hist.push_back(rst_lvl);
      hist.push_back(rst_lvl);
      m_clean   = rst_lvl;
      for (int i = 0; i < N; i++) run[i] = 0;
      cyc       = 0;
      holding   = 0;
      hold_done = 0;
      m_change  = 0;
      m_press   = 0;
      m_rel     = 0;
      m_hold    = 0;
    end else begin
      dly = hist.pop_front();
      hist.push_back({bus.key_raw, bus.sw_raw});
      cyc++;
      upd = '0;
      for (int i = 0; i < N; i++) begin
        if (dly[i] != m_clean[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            m_clean[i] = dly[i];
            run[i]     = 0;
            upd[i]     = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_change = |upd[SW-1:0];
      m_press  = 0;
      m_rel    = 0;
      m_hold   = 0;
      if (upd[SW] && !m_clean[SW]) begin
        m_press   = 1;
        press_at  = cyc;
        holding   = 1;
        hold_done = 0;
      end else if (upd[SW] && m_clean[SW]) begin
        m_rel   = 1;
        holding = 0;
      end else if (holding && !hold_done &&
                   cyc == press_at + HOLD) begin
        m_hold    = 1;
        hold_done = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("m_sw_clean", 32'(bus.sw_clean),
        32'(m_clean[SW-1:0]));
    chk("m_sw_change", 32'(bus.sw_change), 32'(m_change));
    chk("m_key_pressed", 32'(bus.key_pressed),
        32'(!m_clean[SW]));
    chk("m_press", 32'(bus.key_press_pulse), 32'(m_press));
    chk("m_release", 32'(bus.key_release_pulse),
        32'(m_rel));
    chk("m_hold", 32'(bus.key_hold_pulse), 32'(m_hold));
    if (bus.key_hold_pulse === 1'b1) n_hold++;
  end

  // ---------------- directed stimulus ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sw_clean"}, 32'(bus.sw_clean), 0);
    chk({tag, "_sw_change"}, 32'(bus.sw_change), 0);
    chk({tag, "_key_pressed"}, 32'(bus.key_pressed), 0);
    chk({tag, "_press"}, 32'(bus.key_press_pulse), 0);
    chk({tag, "_release"}, 32'(bus.key_release_pulse), 0);
    chk({tag, "_hold"}, 32'(bus.key_hold_pulse), 0);
  endtask

  initial begin
    // 1: reset with inputs active
    bus.sw_raw  = 10'h3FF;
    bus.key_raw = 1'b0;
    edges(3);
    chk_all_zero("rst");
    rst_n = 1'b1;
    edges(5);
    chk("s1_e5_sw_clean", 32'(bus.sw_clean), 0);
    chk("s1_e5_press", 32'(bus.key_press_pulse), 0);
    edges(1);
    chk("s1_e6_sw_clean", 32'(bus.sw_clean), 32'h3FF);
    chk("s1_e6_sw_change", 32'(bus.sw_change), 1);
    chk("s1_e6_press", 32'(bus.key_press_pulse), 1);
    chk("s1_e6_key_pressed", 32'(bus.key_pressed), 1);
    bus.sw_raw  = '0;
    bus.key_raw = 1'b1;
    edges(20);

    // 2: three-cycle glitch is rejected
    bus.sw_raw = 10'h002;
    edges(3);
    bus.sw_raw = '0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      chk("s2_sw_change", 32'(bus.sw_change), 0);
    end
    chk("s2_sw_clean", 32'(bus.sw_clean), 0);

    // 3: clean switch changes
    bus.sw_raw = 10'h002;
    edges(5);
    chk("s3_e5_sw_clean", 32'(bus.sw_clean), 0);
    edges(1);
    chk("s3_e6_sw_clean", 32'(bus.sw_clean), 32'h002);
    chk("s3_e6_sw_change", 32'(bus.sw_change), 1);
    edges(1);
    chk("s3_e7_sw_change", 32'(bus.sw_change), 0);
    bus.sw_raw = 10'h006;
    edges(5);
    chk("s3b_e5_sw_clean", 32'(bus.sw_clean), 32'h002);
    edges(1);
    chk("s3b_e6_sw_clean", 32'(bus.sw_clean), 32'h006);
    chk("s3b_e6_sw_change", 32'(bus.sw_change), 1);
    bus.sw_raw = '0;
    edges(10);

    // 4: long press, 20 cycles
    n_hold = 0;
    bus.key_raw = 1'b0;
    edges(6);
    chk("s4_e6_press", 32'(bus.key_press_pulse), 1);
    edges(7);
    chk("s4_e13_hold", 32'(bus.key_hold_pulse), 0);
    edges(1);
    chk("s4_e14_hold", 32'(bus.key_hold_pulse), 1);
    chk("s4_e14_key_pressed", 32'(bus.key_pressed), 1);
    edges(6);
    bus.key_raw = 1'b1;
    edges(5);
    chk("s4_r5_release", 32'(bus.key_release_pulse), 0);
    chk("s4_r5_key_pressed", 32'(bus.key_pressed), 1);
    edges(1);
    chk("s4_r6_release", 32'(bus.key_release_pulse), 1);
    chk("s4_r6_key_pressed", 32'(bus.key_pressed), 0);
    chk("s4_hold_count", 32'(n_hold), 1);
    edges(10);

    // 5a: short press
    n_hold = 0;
    bus.key_raw = 1'b0;
    edges(6);
    chk("s5a_press", 32'(bus.key_press_pulse), 1);
    bus.key_raw = 1'b1;
    edges(6);
    chk("s5a_release", 32'(bus.key_release_pulse), 1);
    edges(10);
    chk("s5a_hold_count", 32'(n_hold), 0);

    // 5b: release lands on the hold-terminal edge
    bus.key_raw = 1'b0;
    edges(8);
    chk("s5b_key_pressed", 32'(bus.key_pressed), 1);
    bus.key_raw = 1'b1;
    edges(5);
    chk("s5b_e13_release", 32'(bus.key_release_pulse), 0);
    edges(1);
    chk("s5b_e14_release", 32'(bus.key_release_pulse), 1);
    chk("s5b_e14_hold", 32'(bus.key_hold_pulse), 0);
    edges(4);
    chk("s5b_hold_count", 32'(n_hold), 0);
    chk("s5b_key_pressed_end", 32'(bus.key_pressed), 0);

    // 6: reset while HELD and mid-debounce on sw[2]
    bus.key_raw = 1'b0;
    edges(16);
    chk("s6_held_pressed", 32'(bus.key_pressed), 1);
    bus.sw_raw = 10'h004;
    edges(4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("s6_rst");
    bus.sw_raw  = '0;
    bus.key_raw = 1'b1;
    edges(3);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      chk("s6_release", 32'(bus.key_release_pulse), 0);
      chk("s6_sw_change", 32'(bus.sw_change), 0);
    end
    chk("s6_sw_clean", 32'(bus.sw_clean), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
